// File: rtl/pipeline_ctrl.sv
// Hazard, stall, flush and forwarding controller for the 5-stage RV32 pipeline.
// Tracks variable-latency IMem/DMem handshakes with timeout and counts stalled fetch cycles.
module pipeline_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int FORWARD_EN = 1,
    parameter int MAX_WAIT   = 16,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1_addr,
    input  logic [REG_ADDR_W-1:0] ex_rs2_addr,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_rd_we,
    input  logic                  ex_is_load,
    input  logic                  ex_valid,
    input  logic                  ex_redirect,
    input  logic [REG_ADDR_W-1:0] ma_rd_addr,
    input  logic                  ma_rd_we,
    input  logic                  ma_valid,
    input  logic                  ma_mem_op,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_rd_we,
    input  logic                  wb_valid,
    input  logic                  if_fetch,
    input  logic                  imem_resp_valid,
    input  logic                  dmem_resp_valid,
    output logic                  imem_req_valid,
    output logic                  dmem_req_valid,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  stall_ex,
    output logic                  stall_ma,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic [1:0]            forward_rs1,
    output logic [1:0]            forward_rs2,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic {D_IDLE, D_WAIT} d_state_t;
    typedef enum logic {I_IDLE, I_WAIT} i_state_t;

    d_state_t          d_state_reg, d_state_next;
    i_state_t          i_state_reg, i_state_next;
    logic [WAIT_W-1:0] d_cnt_reg, d_cnt_next;
    logic [WAIT_W-1:0] i_cnt_reg, i_cnt_next;
    logic              mem_timeout_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic run;
    logic d_op, d_stall, d_expired;
    logic i_stall, i_expired;
    logic ma_stall, if_wait, raw_stall, redirect_act;
    logic stall_id_c, stall_if_c;
    logic ex_wr, ex_load_wr, ma_wr, wb_wr;
    logic [1:0] load_hit, ex_hit, ma_hit, fwd_ma, fwd_wb;

    assign run  = !reset;
    assign d_op = ma_valid & ma_mem_op;

    // DMem handshake: a response in the request cycle never stalls
    always_comb begin
        d_state_next = d_state_reg;
        d_cnt_next   = d_cnt_reg;
        d_stall      = 1'b0;
        d_expired    = 1'b0;
        case (d_state_reg)
            D_IDLE: begin
                d_cnt_next = '0;
                if (d_op && !dmem_resp_valid) begin
                    d_stall      = 1'b1;
                    d_state_next = D_WAIT;
                    d_cnt_next   = WAIT_W'(1);
                end
            end
            D_WAIT: begin
                if (dmem_resp_valid) begin
                    d_state_next = D_IDLE;
                    d_cnt_next   = '0;
                end else if (d_cnt_reg >= WAIT_LIMIT) begin
                    d_expired    = 1'b1;
                    d_state_next = D_IDLE;
                    d_cnt_next   = '0;
                end else begin
                    d_stall    = 1'b1;
                    d_cnt_next = d_cnt_reg + WAIT_W'(1);
                end
            end
        endcase
    end

    assign ma_stall     = run & d_stall;
    // A redirect is held in EX until a DMem stall clears, then acted on
    assign redirect_act = run & ex_valid & ex_redirect & !ma_stall;

    always_comb begin
        i_state_next = i_state_reg;
        i_cnt_next   = i_cnt_reg;
        i_stall      = 1'b0;
        i_expired    = 1'b0;
        case (i_state_reg)
            I_IDLE: begin
                i_cnt_next = '0;
                if (if_fetch && !imem_resp_valid) begin
                    i_stall      = 1'b1;
                    i_state_next = I_WAIT;
                    i_cnt_next   = WAIT_W'(1);
                end
            end
            I_WAIT: begin
                if (imem_resp_valid) begin
                    i_state_next = I_IDLE;
                    i_cnt_next   = '0;
                end else if (i_cnt_reg >= WAIT_LIMIT) begin
                    i_expired    = 1'b1;
                    i_state_next = I_IDLE;
                    i_cnt_next   = '0;
                end else begin
                    i_stall    = 1'b1;
                    i_cnt_next = i_cnt_reg + WAIT_W'(1);
                end
            end
        endcase
        if (redirect_act) begin
            i_state_next = I_IDLE;
            i_cnt_next   = '0;
            i_expired    = 1'b0;
        end
    end

    assign if_wait = run & i_stall & !redirect_act;

    assign ex_wr      = ex_valid & ex_rd_we & (ex_rd_addr != '0);
    assign ex_load_wr = ex_wr & ex_is_load;
    assign ma_wr      = ma_valid & ma_rd_we & (ma_rd_addr != '0);
    assign wb_wr      = wb_valid & wb_rd_we & (wb_rd_addr != '0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            logic [REG_ADDR_W-1:0] id_src;
            logic [REG_ADDR_W-1:0] ex_src;
            logic                  id_used;
            assign id_src  = (gi == 0) ? id_rs1_addr : id_rs2_addr;
            assign ex_src  = (gi == 0) ? ex_rs1_addr : ex_rs2_addr;
            assign id_used = (gi == 0) ? id_uses_rs1 : id_uses_rs2;

            assign load_hit[gi] = id_used & ex_load_wr & (id_src == ex_rd_addr);
            assign ex_hit[gi]   = id_used & ex_wr & (id_src == ex_rd_addr);
            assign ma_hit[gi]   = id_used & ma_wr & (id_src == ma_rd_addr);
            assign fwd_ma[gi]   = ma_wr & (ex_src == ma_rd_addr);
            assign fwd_wb[gi]   = wb_wr & (ex_src == wb_rd_addr);
        end
    endgenerate

    // WB hits are absent on purpose: the register file writes through
    assign raw_stall = run & !redirect_act &
                       ((|load_hit) | ((FORWARD_EN == 0) ? ((|ex_hit) | (|ma_hit)) : 1'b0));

    assign stall_id_c = ma_stall | raw_stall;
    assign stall_if_c = stall_id_c | if_wait;

    assign imem_req_valid = run & if_fetch;
    assign dmem_req_valid = run & d_op;
    assign stall_ma       = ma_stall;
    assign stall_ex       = ma_stall;
    assign stall_id       = stall_id_c;
    assign stall_if       = stall_if_c;
    assign flush_ex       = reset | redirect_act | (raw_stall & !ma_stall);
    assign flush_id       = reset | redirect_act | (if_wait & !stall_id_c);
    assign forward_rs1    = (run && FORWARD_EN != 0) ? {fwd_ma[0], ~fwd_ma[0] & fwd_wb[0]} : 2'b00;
    assign forward_rs2    = (run && FORWARD_EN != 0) ? {fwd_ma[1], ~fwd_ma[1] & fwd_wb[1]} : 2'b00;
    assign mem_timeout    = mem_timeout_reg;
    assign stall_cycles   = stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_state_reg     <= D_IDLE;
            i_state_reg     <= I_IDLE;
            d_cnt_reg       <= '0;
            i_cnt_reg       <= '0;
            mem_timeout_reg <= 1'b0;
            stall_cnt_reg   <= '0;
        end else begin
            d_state_reg <= d_state_next;
            i_state_reg <= i_state_next;
            d_cnt_reg   <= d_cnt_next;
            i_cnt_reg   <= i_cnt_next;
            if (d_expired || i_expired)
                mem_timeout_reg <= 1'b1;
            if (stall_if_c && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Centralised hazard, stall and flush controller for the 5-stage RV32 pipeline: IF, ID, EX, MA, WB.
- Replaces the fixed one-cycle load/store stall and the standalone forwarding unit.
- Handles variable-latency IMem/DMem handshakes, load-use interlock, branch/jump redirect flushes and operand forwarding selection.
- Adds a memory-timeout error flag and a stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5: register address width; 4 gives RV32E.
- FORWARD_EN, 1: 1 enables MA/WB forwarding; 0 makes every RAW against EX/MA a stall.
- MAX_WAIT, 16: maximum response wait cycles per memory access before timeout, range 1..255.
- CNT_W, 32: stall counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_rs1_addr, id_rs2_addr  in  REG_ADDR_W  source regs of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1/rs2
- ex_rs1_addr, ex_rs2_addr  in  REG_ADDR_W  source regs of the instruction in EX
- ex_rd_addr  in  REG_ADDR_W;  ex_rd_we, ex_is_load, ex_valid, ex_redirect  in  1
- ma_rd_addr  in  REG_ADDR_W;  ma_rd_we, ma_valid, ma_mem_op  in  1  (ma_mem_op = load or store in MA)
- wb_rd_addr  in  REG_ADDR_W;  wb_rd_we, wb_valid  in  1
- if_fetch  in  1  IF wants an instruction
- imem_resp_valid, dmem_resp_valid  in  1
- imem_req_valid, dmem_req_valid  out  1
- stall_if, stall_id, stall_ex, stall_ma  out  1  hold stage input register
- flush_id, flush_ex  out  1  load bubble into ID / EX input register
- forward_rs1, forward_rs2  out  2  00 register file, 10 MA result, 01 WB result
- mem_timeout  out  1  sticky error
- stall_cycles  out  CNT_W  saturating count of cycles with stall_if=1

Behaviour:
- Reset (registered state):
  - Both FSMs go to IDLE.
  - Wait counters, mem_timeout and stall_cycles are cleared.
- While reset is high:
  - All req_valid and stall outputs are 0.
  - flush_id=flush_ex=1.
  - forward_*=00.
- DMem FSM, states D_IDLE and D_WAIT:
  - dmem_req_valid = ma_valid & ma_mem_op & (state D_IDLE or D_WAIT).
  - Zero-wait: if dmem_resp_valid arrives in the request cycle, there is no stall and the FSM stays in D_IDLE.
  - Otherwise the FSM enters D_WAIT. The wait counter increments each cycle, and ma_stall=1 until dmem_resp_valid, which returns the FSM to D_IDLE with ma_stall=0 in that cycle.
  - Back-to-back memory ops: the next op may request the cycle after the previous response.
  - Timeout: if the counter reaches MAX_WAIT in D_WAIT without a response:
    - mem_timeout is set (sticky until reset).
    - The FSM returns to D_IDLE and the stall is released that cycle, so the access is dropped.
    - A late response while in D_IDLE with no memory op is ignored.
- IMem FSM, states I_IDLE and I_WAIT:
  - Same scheme, driven by if_fetch/imem_resp_valid, producing if_wait.
  - Timeout also sets mem_timeout.
- Stall composition:
  - stall_ma = ma_stall.
  - stall_ex = ma_stall.
  - stall_id = ma_stall | raw_stall.
  - stall_if = ma_stall | raw_stall | if_wait.
- raw_stall:
  - Load-use: ex_valid & ex_is_load & ex_rd_we & ex_rd_addr!=0 & ID uses a reg equal to ex_rd_addr.
  - When FORWARD_EN=0, also any ID source matching a valid, writing, nonzero rd in EX or MA.
  - WB matches never stall; the register file is write-through.
- Bubbles:
  - flush_ex = raw_stall & !ma_stall: one bubble into EX per raw_stall cycle.
  - flush_id = if_wait & !stall_id: bubble into ID while a fetch is pending.
- Redirect (ex_redirect & ex_valid):
  - Forces flush_id=flush_ex=1 and suppresses raw_stall and if_wait effects that cycle.
  - If ma_stall=1, the redirect is not acted on (no flush) until EX advances; ex_redirect must be held by EX.
  - A pending IMem access is abandoned on redirect: the FSM returns to I_IDLE.
- Forwarding, combinational, per operand, when FORWARD_EN=1:
  - 10 if ma_valid & ma_rd_we & ma_rd_addr!=0 & ma_rd_addr==ex_rsN_addr.
  - Else 01 for the same condition on WB.
  - Else 00.
  - MA has priority. When FORWARD_EN=0, always 00.
- Address 0 never forwards or stalls.
- stall_cycles increments when stall_if=1 and saturates at all ones.

Test Plan:
- Load x5 in EX, ID add x6,x5,x1 -> one cycle stall_if=stall_id=1 and flush_ex=1; the next cycle has no stall and forward_rs1=10 (load result now in MA).
- MA load, dmem_resp_valid arrives 3 cycles after request -> stall_ma/ex/id/if=1 for exactly 3 cycles, dmem_req_valid held 4 cycles, stall_cycles=3.
- MA store, no response, MAX_WAIT=16 -> stall for 16 cycles, then mem_timeout=1 stays high; stall released; a late response is ignored.
- ex_redirect=1 in the same cycle as a load-use match -> flush_id=flush_ex=1, stall_id=0; ex_redirect during a DMem wait -> no flush until the response cycle.
- MA and WB both write x7, EX reads x7 in rs1 and rs2 -> forward_rs1=forward_rs2=10; rd=x0 case -> 00; FORWARD_EN=0 with an EX writer of x7 -> raw_stall.
- Reset asserted mid-D_WAIT -> next cycle FSM in D_IDLE, dmem_req_valid=0, mem_timeout=0, stall_cycles=0.
